core_top: RTL and testbench



---
 rtl/core_top.sv | 254 +++++++++++++++++++++++++
 tb/tb_core_top.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_top.sv
// Single-cycle RV32I processor: instruction ROM, data RAM, register file and core.
// Fetch and data reads are combinational; all architectural state updates on clk.

module insn_mem #(
    parameter int unsigned WORDS = 1024
) (
    input  logic [29:0] word_addr,
    output logic [31:0] insn
);
    localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0]   mem [0:WORDS-1];
    logic [AW-1:0] idx;

    assign idx  = AW'({2'b00, word_addr} % WORDS);
    assign insn = mem[idx];
endmodule

module data_mem #(
    parameter int unsigned WORDS = 1024
) (
    input  logic        clk,
    input  logic [29:0] word_addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  logic        we,
    output logic [31:0] rdata
);
    localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0]   mem [0:WORDS-1];
    logic [AW-1:0] idx;

    assign idx   = AW'({2'b00, word_addr} % WORDS);
    assign rdata = mem[idx];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end
endmodule

module regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  rd,
    input  logic [31:0] wdata,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] regFile [0:31];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) regFile[i] <= '0;
        end else if (we && rd != '0) begin
            regFile[rd] <= wdata;
        end
    end

    assign rd1 = (rs1 == '0) ? '0 : regFile[rs1];
    assign rd2 = (rs2 == '0) ? '0 : regFile[rs2];
endmodule

module rv32i_core #(
    parameter logic [31:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] insn,
    output logic [29:0] fetch_addr,
    output logic [29:0] dmem_word_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        dmem_we,
    input  logic [31:0] dmem_rdata
);
    typedef enum logic [6:0] {
        OP_LUI    = 7'h37,
        OP_AUIPC  = 7'h17,
        OP_JAL    = 7'h6F,
        OP_JALR   = 7'h67,
        OP_BRANCH = 7'h63,
        OP_LOAD   = 7'h03,
        OP_STORE  = 7'h23,
        OP_IMM    = 7'h13,
        OP_REG    = 7'h33
    } opcode_e;

    logic [31:0] pc, next_pc, pc_plus4;
    logic [31:0] rs1v, rs2v, rf_wdata, mem_addr, store_wdata;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [3:0]  store_be;
    logic        rf_we, store_en, taken;
    logic [2:0]  f3;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign f3       = insn[14:12];
    assign imm_i    = {{20{insn[31]}}, insn[31:20]};
    assign imm_s    = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign imm_b    = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign imm_u    = {insn[31:12], 12'b0};
    assign imm_j    = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    assign pc_plus4 = pc + 32'd4;

    regfile register_file (
        .clk(clk), .reset(reset), .we(rf_we), .rd(insn[11:7]), .wdata(rf_wdata),
        .rs1(insn[19:15]), .rs2(insn[24:20]), .rd1(rs1v), .rd2(rs2v)
    );

    // alt selects SUB / SRA; kept as if/else so SRA stays an arithmetic shift
    function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'b000:  r = alt ? a - b : a + b;
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'b0, $signed(a) < $signed(b)};
            3'b011:  r = {31'b0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  if (alt) r = $signed(a) >>> b[4:0];
                     else     r = a >> b[4:0];
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    assign ld_byte = dmem_rdata[8*mem_addr[1:0] +: 8];
    assign ld_half = mem_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        next_pc     = pc_plus4;
        rf_we       = 1'b0;
        rf_wdata    = '0;
        store_en    = 1'b0;
        store_be    = '0;
        store_wdata = '0;
        taken       = 1'b0;
        mem_addr    = rs1v + imm_i;
        case (insn[6:0])
            OP_LUI:   begin rf_we = 1'b1; rf_wdata = imm_u; end
            OP_AUIPC: begin rf_we = 1'b1; rf_wdata = pc + imm_u; end
            OP_JAL: begin
                rf_we    = 1'b1;
                rf_wdata = pc_plus4;
                next_pc  = pc + imm_j;
            end
            OP_JALR: if (f3 == 3'b000) begin
                rf_we    = 1'b1;
                rf_wdata = pc_plus4;
                next_pc  = (rs1v + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                case (f3)
                    3'b000:  taken = (rs1v == rs2v);
                    3'b001:  taken = (rs1v != rs2v);
                    3'b100:  taken = ($signed(rs1v) <  $signed(rs2v));
                    3'b101:  taken = ($signed(rs1v) >= $signed(rs2v));
                    3'b110:  taken = (rs1v <  rs2v);
                    3'b111:  taken = (rs1v >= rs2v);
                    default: taken = 1'b0;
                endcase
                if (taken) next_pc = pc + imm_b;
            end
            OP_LOAD: begin
                rf_we = 1'b1;
                case (f3)
                    3'b000:  rf_wdata = {{24{ld_byte[7]}}, ld_byte};
                    3'b001:  rf_wdata = {{16{ld_half[15]}}, ld_half};
                    3'b010:  rf_wdata = dmem_rdata;
                    3'b100:  rf_wdata = {24'b0, ld_byte};
                    3'b101:  rf_wdata = {16'b0, ld_half};
                    default: rf_we = 1'b0;
                endcase
            end
            OP_STORE: begin
                mem_addr = rs1v + imm_s;
                store_en = 1'b1;
                case (f3)
                    3'b000: begin
                        store_be    = 4'b0001 << mem_addr[1:0];
                        store_wdata = {4{rs2v[7:0]}};
                    end
                    3'b001: begin
                        store_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
                        store_wdata = {2{rs2v[15:0]}};
                    end
                    3'b010: begin
                        store_be    = 4'b1111;
                        store_wdata = rs2v;
                    end
                    default: store_en = 1'b0;
                endcase
            end
            OP_IMM: begin
                rf_we    = 1'b1;
                rf_wdata = alu(f3, (f3 == 3'b101) && insn[30], rs1v, imm_i);
            end
            OP_REG: begin
                rf_we    = 1'b1;
                rf_wdata = alu(f3, insn[30], rs1v, rs2v);
            end
            default: ;
        endcase
    end

    assign fetch_addr     = pc[31:2];
    assign dmem_word_addr = mem_addr[31:2];
    assign dmem_wdata     = store_wdata;
    assign dmem_be        = store_be;
    assign dmem_we        = store_en && !reset;

    always_ff @(posedge clk) begin
        if (reset) pc <= RESET_PC;
        else       pc <= next_pc;
    end
endmodule

module core_top #(
    parameter int unsigned IMEM_WORDS = 1024,
    parameter int unsigned DMEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clk,
    input logic reset
);
    logic [29:0] fetch_addr, dmem_word_addr;
    logic [31:0] insn, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_we;

    insn_mem #(.WORDS(IMEM_WORDS)) insn_memory (
        .word_addr(fetch_addr), .insn(insn)
    );

    rv32i_core #(.RESET_PC(RESET_PC)) main_core (
        .clk(clk), .reset(reset), .insn(insn), .fetch_addr(fetch_addr),
        .dmem_word_addr(dmem_word_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_we(dmem_we), .dmem_rdata(dmem_rdata)
    );

    data_mem #(.WORDS(DMEM_WORDS)) data_memory (
        .clk(clk), .word_addr(dmem_word_addr), .wdata(dmem_wdata), .be(dmem_be),
        .we(dmem_we), .rdata(dmem_rdata)
    );
endmodule

// File: tb/tb_core_top.sv
// Directed-program bench for core_top: expected architectural state is queued
// by the stimulus and checked by an independent monitor on the falling edge.

module tb_core_top;
    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    core_top #(.IMEM_WORDS(1024), .DMEM_WORDS(1024), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset)
    );

    localparam int K_PC = 0, K_REG = 1, K_IMEM = 2, K_DMEM = 3;

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        cur;
    logic [31:0] act;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] i_t(logic [6:0] op, int rd, int f3, int rs1, int imm);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return i_t(7'h13, rd, 0, rs1, imm);
    endfunction
    function automatic logic [31:0] r_t(int f7, int f3, int rd, int rs1, int rs2);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] s_t(int f3, int rs1, int rs2, int imm);
        logic [11:0] m = 12'(imm);
        return {m[11:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_t(int f3, int rs1, int rs2, int imm);
        logic [12:0] m = 13'(imm);
        return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'h63};
    endfunction
    function automatic logic [31:0] u_t(logic [6:0] op, int rd, int imm20);
        return {20'(imm20), 5'(rd), op};
    endfunction
    function automatic logic [31:0] j_t(int rd, int imm);
        logic [20:0] m = 21'(imm);
        return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6F};
    endfunction
    function automatic logic [31:0] halt();
        return j_t(0, 0);
    endfunction

    // ---------------- scoreboard ----------------
    function automatic void exp_push(int kind, int idx, logic [31:0] val, string name);
        exp_t e;
        e.kind = kind; e.idx = idx; e.val = val; e.name = name;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        while (sb.size() != 0) begin
            cur = sb.pop_front();
            case (cur.kind)
                K_PC:    act = dut.main_core.pc;
                K_REG:   act = dut.main_core.register_file.regFile[cur.idx];
                K_IMEM:  act = dut.insn_memory.mem[cur.idx];
                default: act = dut.data_memory.mem[cur.idx];
            endcase
            n_cmp++;
            if (act !== cur.val) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", cur.name, act, cur.val);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    // ---------------- sequencing helpers (entered at a falling edge) ----------------
    task automatic load_prog();
        for (int i = 0; i < 1024; i++)
            dut.insn_memory.mem[i] = (i < prog.size()) ? prog[i] : 32'h0000_0013;
    endtask

    task automatic hold_reset(int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(int n);
        reset = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_cleared(string tag);
        exp_push(K_PC, 0, 32'h0, {tag, "_pc"});
        for (int r = 0; r < 32; r++) exp_push(K_REG, r, 32'h0, $sformatf("%s_x%0d", tag, r));
    endtask

    initial begin
        // Reset and basic sequencing
        reset = 1'b1;
        prog = '{addi(1, 0, 1), addi(2, 0, 2), addi(3, 0, 3), halt()};
        load_prog();
        hold_reset(2);
        expect_cleared("reset");
        drain();
        run(3);
        exp_push(K_PC, 0, 32'd12, "reset_pc_after3");
        exp_push(K_REG, 3, 32'd3, "reset_x3");
        drain();

        // ALU
        reset = 1'b1;
        prog = '{addi(1, 0, 5), addi(2, 0, -3), r_t(0, 0, 3, 1, 2), r_t(32, 0, 4, 2, 1),
                 r_t(0, 3, 5, 1, 2), i_t(7'h13, 6, 5, 2, 12'h401), r_t(0, 2, 7, 2, 1),
                 i_t(7'h13, 9, 1, 1, 3), i_t(7'h13, 10, 5, 2, 28), r_t(32, 5, 11, 2, 1),
                 i_t(7'h13, 12, 2, 2, -2), i_t(7'h13, 13, 3, 1, -1), i_t(7'h13, 14, 4, 1, -1),
                 r_t(0, 7, 15, 1, 2), r_t(0, 6, 16, 1, 2), halt()};
        load_prog();
        hold_reset(1);
        run(20);
        exp_push(K_REG, 3, 32'h0000_0002, "alu_add");
        exp_push(K_REG, 4, 32'hFFFF_FFF8, "alu_sub");
        exp_push(K_REG, 5, 32'h0000_0001, "alu_sltu");
        exp_push(K_REG, 6, 32'hFFFF_FFFE, "alu_srai");
        exp_push(K_REG, 7, 32'h0000_0001, "alu_slt");
        exp_push(K_REG, 9, 32'h0000_0028, "alu_slli");
        exp_push(K_REG, 10, 32'h0000_000F, "alu_srli");
        exp_push(K_REG, 11, 32'hFFFF_FFFF, "alu_sra");
        exp_push(K_REG, 12, 32'h0000_0001, "alu_slti");
        exp_push(K_REG, 13, 32'h0000_0001, "alu_sltiu");
        exp_push(K_REG, 14, 32'hFFFF_FFFA, "alu_xori");
        exp_push(K_REG, 15, 32'h0000_0005, "alu_and");
        exp_push(K_REG, 16, 32'hFFFF_FFFD, "alu_or");
        drain();

        // x0 and upper immediates
        reset = 1'b1;
        prog = '{addi(0, 0, 7), u_t(7'h37, 7, 20'h12345), u_t(7'h17, 8, 1), halt()};
        load_prog();
        hold_reset(1);
        run(6);
        exp_push(K_REG, 0, 32'h0, "x0_zero");
        exp_push(K_REG, 7, 32'h1234_5000, "lui");
        exp_push(K_REG, 8, 32'h0000_1008, "auipc");
        drain();

        // Loads and stores
        reset = 1'b1;
        prog = '{addi(1, 0, -128), s_t(2, 0, 1, 16), s_t(0, 0, 0, 17),
                 i_t(7'h03, 2, 2, 0, 16), i_t(7'h03, 3, 0, 0, 16), i_t(7'h03, 4, 4, 0, 16),
                 i_t(7'h03, 5, 1, 0, 16), i_t(7'h03, 7, 5, 0, 18), s_t(1, 0, 1, 22),
                 i_t(7'h03, 8, 5, 0, 22), i_t(7'h03, 9, 1, 0, 19), halt()};
        load_prog();
        hold_reset(1);
        run(15);
        exp_push(K_DMEM, 4, 32'hFFFF_0080, "mem_word4");
        exp_push(K_REG, 2, 32'hFFFF_0080, "mem_lw");
        exp_push(K_REG, 3, 32'hFFFF_FF80, "mem_lb");
        exp_push(K_REG, 4, 32'h0000_0080, "mem_lbu");
        exp_push(K_REG, 5, 32'h0000_0080, "mem_lh");
        exp_push(K_REG, 7, 32'h0000_FFFF, "mem_lhu_hi");
        exp_push(K_REG, 8, 32'h0000_FF80, "mem_sh_lhu");
        exp_push(K_REG, 9, 32'hFFFF_FFFF, "mem_lh_odd");
        drain();

        // Branches and jumps
        reset = 1'b1;
        prog = '{addi(1, 0, -1), addi(2, 0, 1), b_t(0, 1, 2, 8), b_t(4, 1, 2, 8),
                 addi(10, 0, 99), b_t(6, 1, 2, 8), addi(11, 0, 7), b_t(5, 1, 2, 8),
                 j_t(1, 8), halt(), addi(12, 0, 5), i_t(7'h67, 0, 0, 1, 0)};
        load_prog();
        hold_reset(1);
        run(14);
        exp_push(K_PC, 0, 32'h0000_0024, "ctl_jalr_pc");
        exp_push(K_REG, 1, 32'h0000_0024, "ctl_jal_link");
        exp_push(K_REG, 10, 32'h0, "ctl_blt_skip");
        exp_push(K_REG, 11, 32'h0000_0007, "ctl_bltu_fall");
        exp_push(K_REG, 12, 32'h0000_0005, "ctl_jal_target");
        drain();

        // JALR with rd == rs1 and misaligned targets
        reset = 1'b1;
        prog = '{addi(3, 0, 16), i_t(7'h67, 3, 0, 3, 5), 32'h0000_0013, halt(),
                 32'h0000_0013, i_t(7'h67, 0, 0, 3, 7)};
        load_prog();
        hold_reset(1);
        run(8);
        exp_push(K_REG, 3, 32'h0000_0008, "jalr_link");
        exp_push(K_PC, 0, 32'h0000_000E, "jalr_misaligned_pc");
        drain();

        // Countdown loop
        reset = 1'b1;
        prog = '{addi(5, 0, 10), addi(5, 5, -1), addi(6, 6, 1), b_t(1, 5, 0, -8),
                 s_t(2, 0, 6, 0), halt()};
        load_prog();
        hold_reset(1);
        run(40);
        exp_push(K_REG, 5, 32'h0, "loop_counter");
        exp_push(K_REG, 6, 32'd10, "loop_iters");
        exp_push(K_DMEM, 0, 32'd10, "loop_store");
        exp_push(K_PC, 0, 32'd20, "loop_pc");
        drain();

        // Reset in the middle of the loop
        hold_reset(1);
        run(5);
        hold_reset(1);
        expect_cleared("midrst");
        for (int i = 0; i < prog.size(); i++)
            exp_push(K_IMEM, i, prog[i], $sformatf("midrst_imem%0d", i));
        exp_push(K_DMEM, 0, 32'd10, "midrst_dmem");
        drain();

        // Store in the reset cycle must not commit
        prog = '{addi(1, 0, 32'h55), s_t(2, 0, 1, 0), halt()};
        load_prog();
        hold_reset(1);
        run(1);
        hold_reset(1);
        exp_push(K_DMEM, 0, 32'd10, "rst_store_blocked");
        exp_push(K_PC, 0, 32'h0, "rst_store_pc");
        drain();
        run(5);
        exp_push(K_DMEM, 0, 32'h0000_0055, "store_after_rst");
        exp_push(K_PC, 0, 32'd8, "store_after_rst_pc");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
